// File: rtl/mips_cache_units_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cache_units_if
// Description : CPU, fill and write-buffer bus signals of the cache storage block.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_cache_units_if;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_stall;
    logic        instr_data_valid;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic        commit;
    logic [31:0] data_readdata;
    logic        data_stall;
    logic        data_data_valid;
    logic [31:0] mem_readdata;
    logic        wb_active;
    logic        waitrequest;
    logic [31:0] wb_address;
    logic [31:0] wb_writedata;
    logic [3:0]  wb_byteenable;
    logic        wb_write;
    logic [1:0]  wb_state;
    logic        wb_full;
    logic        wb_empty;
    logic        addr_in_wb;

    modport master (
        output instr_read, instr_address, instr_data_valid,
        output data_address, data_read, data_write, data_writedata, data_byteenable,
        output commit, data_data_valid, mem_readdata, wb_active, waitrequest,
        input  instr_readdata, instr_stall, data_readdata, data_stall,
        input  wb_address, wb_writedata, wb_byteenable, wb_write, wb_state,
        input  wb_full, wb_empty, addr_in_wb
    );

    modport slave (
        input  instr_read, instr_address, instr_data_valid,
        input  data_address, data_read, data_write, data_writedata, data_byteenable,
        input  commit, data_data_valid, mem_readdata, wb_active, waitrequest,
        output instr_readdata, instr_stall, data_readdata, data_stall,
        output wb_address, wb_writedata, wb_byteenable, wb_write, wb_state,
        output wb_full, wb_empty, addr_in_wb
    );
endinterface
`default_nettype wire

// File: rtl/mips_cache_units.sv
`default_nettype none
// ============================================================================
// Module      : mips_cache_units
// Description : Direct-mapped I-cache, write-through D-cache and 4-entry
//               posted write buffer for the MIPS CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cache_units (
    input  wire logic           clk,
    input  wire logic           rst,
    mips_cache_units_if.slave   bus
);
    localparam int          c_LINES      = 16;
    localparam int          c_WB_DEPTH   = 4;
    localparam logic [1:0]  c_WB_EMPTY   = 2'd0;
    localparam logic [1:0]  c_WB_PENDING = 2'd1;
    localparam logic [1:0]  c_WB_WRITING = 2'd2;

    // ---------------- instruction cache ----------------
    logic [15:0] r_ic_valid;
    logic [25:0] r_ic_tag  [c_LINES];
    logic [31:0] r_ic_data [c_LINES];
    logic [3:0]  w_ic_idx;
    logic        w_ic_hit;

    assign w_ic_idx           = bus.instr_address[5:2];
    assign w_ic_hit           = r_ic_valid[w_ic_idx] && (r_ic_tag[w_ic_idx] == bus.instr_address[31:6]);
    assign bus.instr_stall    = bus.instr_read && !w_ic_hit;
    assign bus.instr_readdata = w_ic_hit ? r_ic_data[w_ic_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic_valid <= '0;
        end else if (bus.instr_data_valid) begin
            r_ic_valid[w_ic_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.instr_data_valid) begin
            r_ic_tag[w_ic_idx]  <= bus.instr_address[31:6];
            r_ic_data[w_ic_idx] <= bus.mem_readdata;
        end
    end

    // ---------------- data cache ----------------
    logic [15:0] r_dc_valid;
    logic [25:0] r_dc_tag  [c_LINES];
    logic [31:0] r_dc_data [c_LINES];
    logic [3:0]  w_dc_idx;
    logic        w_dc_hit;
    logic        w_dc_store_hit;
    logic [31:0] w_dc_line_new;

    assign w_dc_idx          = bus.data_address[5:2];
    assign w_dc_hit          = r_dc_valid[w_dc_idx] && (r_dc_tag[w_dc_idx] == bus.data_address[31:6]);
    assign w_dc_store_hit    = bus.data_write && bus.commit && w_dc_hit;
    assign bus.data_stall    = bus.data_read && !w_dc_hit;
    assign bus.data_readdata = w_dc_hit ? r_dc_data[w_dc_idx] : 32'd0;

    // A fill lands first; enabled store bytes of a same-cycle store hit overlay it.
    always_comb begin
        w_dc_line_new = bus.data_data_valid ? bus.mem_readdata : r_dc_data[w_dc_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_dc_store_hit && bus.data_byteenable[b]) begin
                w_dc_line_new[8*b +: 8] = bus.data_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dc_valid <= '0;
        end else if (bus.data_data_valid) begin
            r_dc_valid[w_dc_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.data_data_valid) begin
            r_dc_tag[w_dc_idx] <= bus.data_address[31:6];
        end
        if (bus.data_data_valid || w_dc_store_hit) begin
            r_dc_data[w_dc_idx] <= w_dc_line_new;
        end
    end

    // ---------------- write buffer ----------------
    logic [31:0] r_wb_addr [c_WB_DEPTH];
    logic [31:0] r_wb_data [c_WB_DEPTH];
    logic [3:0]  r_wb_be   [c_WB_DEPTH];
    logic [1:0]  r_wb_head;
    logic [1:0]  r_wb_tail;
    logic [2:0]  r_wb_count;
    logic        w_wb_empty;
    logic        w_wb_full;
    logic        w_wb_write;
    logic        w_wb_push;
    logic        w_wb_pop;
    logic [1:0]  w_wb_state;
    logic [3:0]  w_wb_match;

    assign w_wb_empty = (r_wb_count == 3'd0);
    assign w_wb_full  = (r_wb_count == 3'd4);
    assign w_wb_write = bus.wb_active && !w_wb_empty;
    assign w_wb_push  = bus.data_write && bus.commit && !w_wb_full;
    assign w_wb_pop   = w_wb_write && !bus.waitrequest;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_head  <= 2'd0;
            r_wb_tail  <= 2'd0;
            r_wb_count <= 3'd0;
        end else begin
            if (w_wb_push) begin
                r_wb_tail <= r_wb_tail + 2'd1;
            end
            if (w_wb_pop) begin
                r_wb_head <= r_wb_head + 2'd1;
            end
            case ({w_wb_push, w_wb_pop})
                2'b10:   r_wb_count <= r_wb_count + 3'd1;
                2'b01:   r_wb_count <= r_wb_count - 3'd1;
                default: r_wb_count <= r_wb_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb_push) begin
            r_wb_addr[r_wb_tail] <= bus.data_address;
            r_wb_data[r_wb_tail] <= bus.data_writedata;
            r_wb_be[r_wb_tail]   <= bus.data_byteenable;
        end
    end

    // A slot is live when its distance from the head is below the count.
    for (genvar i = 0; i < c_WB_DEPTH; i++) begin : g_wb_match
        localparam logic [1:0] c_SLOT = 2'(i);
        logic [1:0] w_off;
        assign w_off         = c_SLOT - r_wb_head;
        assign w_wb_match[i] = ({1'b0, w_off} < r_wb_count) &&
                               (r_wb_addr[i][31:2] == bus.data_address[31:2]);
    end

    always_comb begin
        w_wb_state = c_WB_PENDING;
        if (w_wb_empty) begin
            w_wb_state = c_WB_EMPTY;
        end else if (w_wb_write) begin
            w_wb_state = c_WB_WRITING;
        end
    end

    assign bus.wb_address    = w_wb_empty ? 32'd0 : r_wb_addr[r_wb_head];
    assign bus.wb_writedata  = w_wb_empty ? 32'd0 : r_wb_data[r_wb_head];
    assign bus.wb_byteenable = w_wb_empty ? 4'd0  : r_wb_be[r_wb_head];
    assign bus.wb_write      = w_wb_write;
    assign bus.wb_state      = w_wb_state;
    assign bus.wb_full       = w_wb_full;
    assign bus.wb_empty      = w_wb_empty;
    assign bus.addr_in_wb    = |w_wb_match;

    logic w_unused;
    assign w_unused = ^{bus.instr_address[1:0], bus.data_address[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_mips_cache_units.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cache_units
// Description : Directed self-checking bench with write-buffer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cache_units;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wb_ent_t;
    wb_ent_t sb[$];

    mips_cache_units_if bus ();

    mips_cache_units dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks buffer outputs against the model, then advances one clock edge.
    task automatic tick();
        logic       full_b;
        logic [1:0] st;
        #1;
        st = (sb.size() == 0) ? 2'd0 : (bus.wb_active ? 2'd2 : 2'd1);
        chk("wb_empty", bus.wb_empty, sb.size() == 0);
        chk("wb_full", bus.wb_full, sb.size() == 4);
        chk("wb_write", bus.wb_write, bus.wb_active && sb.size() != 0);
        chk("wb_state", bus.wb_state, st);
        if (sb.size() == 0) begin
            chk("wb_addr_idle", bus.wb_address, 32'd0);
        end
        full_b = (sb.size() == 4);
        if (bus.wb_active && sb.size() != 0 && !bus.waitrequest) begin
            chk("pop_addr", bus.wb_address, sb[0].a);
            chk("pop_data", bus.wb_writedata, sb[0].d);
            chk("pop_be", bus.wb_byteenable, sb[0].be);
            void'(sb.pop_front());
            pops++;
        end
        if (bus.data_write && bus.commit && !full_b) begin
            sb.push_back({bus.data_address, bus.data_writedata, bus.data_byteenable});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.data_address    = a;
        bus.data_writedata  = d;
        bus.data_byteenable = be;
        bus.data_write      = 1'b1;
        bus.commit          = 1'b1;
        tick();
        bus.data_write      = 1'b0;
        bus.commit          = 1'b0;
    endtask

    task automatic drain();
        bus.wb_active   = 1'b1;
        bus.waitrequest = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        #1;
        chk("drain_empty", bus.wb_empty, 1'b1);
        chk("drain_model", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_read = 0; bus.instr_address = 0; bus.instr_data_valid = 0;
        bus.data_address = 0; bus.data_read = 0; bus.data_write = 0;
        bus.data_writedata = 0; bus.data_byteenable = 0; bus.commit = 0;
        bus.data_data_valid = 0; bus.mem_readdata = 0;
        bus.wb_active = 0; bus.waitrequest = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        bus.instr_read = 1; bus.instr_address = 32'h100;
        bus.data_read  = 1; bus.data_address  = 32'h100;
        #1;
        chk("rst_istall", bus.instr_stall, 1'b1);
        chk("rst_dstall", bus.data_stall, 1'b1);
        chk("rst_ird", bus.instr_readdata, 32'd0);
        chk("rst_drd", bus.data_readdata, 32'd0);
        chk("rst_empty", bus.wb_empty, 1'b1);
        chk("rst_full", bus.wb_full, 1'b0);
        chk("rst_wbw", bus.wb_write, 1'b0);
        chk("rst_state", bus.wb_state, 2'd0);
        chk("rst_inwb", bus.addr_in_wb, 1'b0);

        // Cold fetch
        bus.instr_data_valid = 1; bus.mem_readdata = 32'h24020005;
        tick();
        bus.instr_data_valid = 0;
        #1;
        chk("ifill_stall", bus.instr_stall, 1'b0);
        chk("ifill_data", bus.instr_readdata, 32'h24020005);
        chk("dc_separate", bus.data_stall, 1'b1);

        // Conflict miss in the data cache
        bus.data_data_valid = 1; bus.mem_readdata = 32'h11111111;
        tick();
        bus.data_data_valid = 0;
        bus.data_address = 32'h140;
        #1;
        chk("conf_stall", bus.data_stall, 1'b1);
        chk("conf_rd0", bus.data_readdata, 32'd0);
        bus.data_data_valid = 1; bus.mem_readdata = 32'hDEADBEEF;
        tick();
        bus.data_data_valid = 0;
        #1;
        chk("conf_hit", bus.data_stall, 1'b0);
        chk("conf_data", bus.data_readdata, 32'hDEADBEEF);
        bus.data_address = 32'h100;
        #1;
        chk("conf_evict", bus.data_stall, 1'b1);

        // Store hit merge
        bus.data_address = 32'h200;
        bus.data_data_valid = 1; bus.mem_readdata = 32'h11223344;
        tick();
        bus.data_data_valid = 0;
        store(32'h200, 32'hAABBCCDD, 4'b0011);
        bus.data_address = 32'h200;
        #1;
        chk("merge_data", bus.data_readdata, 32'h1122CCDD);
        chk("merge_wba", bus.wb_address, 32'h200);
        chk("merge_wbd", bus.wb_writedata, 32'hAABBCCDD);
        chk("merge_wbe", bus.wb_byteenable, 4'b0011);
        chk("merge_inwb", bus.addr_in_wb, 1'b1);

        // Same-cycle fill and store hit: fill first, store bytes on top
        bus.data_data_valid = 1; bus.mem_readdata = 32'h55667788;
        store(32'h200, 32'h000000EE, 4'b0001);
        bus.data_data_valid = 0;
        bus.data_address = 32'h200;
        #1;
        chk("fillstore", bus.data_readdata, 32'h556677EE);

        // Store miss: no allocate, no stall
        bus.data_read = 0;
        store(32'h600, 32'h66666666, 4'b1111);
        bus.data_read = 1; bus.data_address = 32'h600;
        #1;
        chk("smiss_stall", bus.data_stall, 1'b1);
        chk("smiss_rd", bus.data_readdata, 32'd0);
        drain();
        bus.wb_active = 0;

        // Commit gating
        bus.data_address = 32'h300; bus.data_writedata = 32'h33333333;
        bus.data_byteenable = 4'hF; bus.data_write = 1; bus.commit = 0;
        repeat (3) tick();
        chk("gate_empty", bus.wb_empty, 1'b1);
        bus.commit = 1;
        tick();
        bus.commit = 0; bus.data_write = 0;
        #1;
        chk("gate_one", bus.wb_empty, 1'b0);

        // Fill to four entries, then offer one more while full
        store(32'h400, 32'h44444444, 4'b1100);
        store(32'h500, 32'h55555555, 4'b0110);
        store(32'h700, 32'h77777777, 4'b1111);
        #1;
        chk("full_flag", bus.wb_full, 1'b1);
        chk("full_state", bus.wb_state, 2'd1);
        store(32'h800, 32'h88888888, 4'b1111);

        // Coherency flag
        bus.data_address = 32'h302;
        #1;
        chk("inwb_hit", bus.addr_in_wb, 1'b1);
        bus.data_address = 32'h304;
        #1;
        chk("inwb_miss", bus.addr_in_wb, 1'b0);
        bus.data_address = 32'h800;
        #1;
        chk("inwb_reject", bus.addr_in_wb, 1'b0);

        // Bus stalls the head, then drain in order
        bus.wb_active = 1; bus.waitrequest = 1;
        repeat (2) begin
            #1;
            chk("hold_state", bus.wb_state, 2'd2);
            chk("hold_head", bus.wb_address, 32'h300);
            tick();
        end
        pops = 0;
        drain();
        chk("pop_count", pops, 4);

        // Enqueue and pop in the same cycle
        store(32'h900, 32'h99990000, 4'b1111);
        store(32'h904, 32'h99990004, 4'b1111);
        store(32'h908, 32'h99990008, 4'b1111);
        #1;
        chk("concur_cnt", sb.size() == 1 && bus.wb_address == 32'h908, 1'b1);
        drain();

        // Reset mid-drain discards everything
        bus.wb_active = 0;
        store(32'hA00, 32'hA0A0A0A0, 4'b1111);
        store(32'hA04, 32'hA4A4A4A4, 4'b1111);
        bus.wb_active = 1; bus.waitrequest = 1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
        bus.instr_address = 32'h100; bus.data_address = 32'h200;
        #1;
        chk("rst2_empty", bus.wb_empty, 1'b1);
        chk("rst2_wbw", bus.wb_write, 1'b0);
        chk("rst2_state", bus.wb_state, 2'd0);
        chk("rst2_istall", bus.instr_stall, 1'b1);
        chk("rst2_dstall", bus.data_stall, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
